// File: rtl/step_pkg.sv
// Shared types and default geometry for the step tile map.
package step_pkg;

  typedef enum logic [2:0] {
    FREE  = 3'd0,
    REGU  = 3'd1,
    GATE  = 3'd2,
    COIN  = 3'd3,
    WALL  = 3'd4,
    SPIKE = 3'd5,
    BRAKE = 3'd6
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_EXEC  = 3'd4
  } state_t;

  localparam int DEF_NUM_OF_ROWS    = 7;
  localparam int DEF_NUM_OF_COLS    = 10;
  localparam int DEF_TILE_W         = 64;
  localparam int DEF_TILE_H         = 64;
  localparam int DEF_RESTORE_FRAMES = 120;

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/step_map_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, the last winner loses ties.
// The winner history only advances when en is high and something is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetN,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    last_d = last_q;
    if (en && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // Starting with the enemy as last winner gives the player the first tie.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/step_map_ctrl.sv
// Bumpy step tile map: clear/load sequencing, 1-cycle registered pixel lookup, arbitrated hit RMW (ack 2 cycles after accept).
// STEP_MAP_BRAKE_RESTORE_EN: broken BRAKE tiles are restored RESTORE_FRAMES frames after the latest break.
module step_map_ctrl
  import step_pkg::*;
#(
  parameter int NUM_OF_ROWS    = DEF_NUM_OF_ROWS,
  parameter int NUM_OF_COLS    = DEF_NUM_OF_COLS,
  parameter int TILE_W         = DEF_TILE_W,
  parameter int TILE_H         = DEF_TILE_H,
  parameter int RESTORE_FRAMES = DEF_RESTORE_FRAMES
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic [10:0]     pixelX,
  input  logic [10:0]     pixelY,
  input  logic            startOfFrame,
  input  logic            start_level,
  input  logic            load_valid,
  input  logic [2:0]      load_type,
  output logic            load_ready,
  input  logic [1:0]      hit_valid,
  input  logic [1:0][2:0] hit_row,
  input  logic [1:0][3:0] hit_col,
  output logic [1:0]      hit_ack,
  output logic [10:0]     tileTopLeftX,
  output logic [10:0]     tileTopLeftY,
  output logic [2:0]      step_type,
  output logic [6:0]      coins_collected,
  output logic            coin_pulse,
  output logic            level_done,
  output logic            map_ready
);

  localparam int NTILES   = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int IDXW     = $clog2(NTILES);
  localparam int LAST_IDX = NTILES - 1;
  localparam int TW_SH    = $clog2(TILE_W);
  localparam int TH_SH    = $clog2(TILE_H);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  step_t           map_q [NTILES];
  step_t           map_d [NTILES];
  logic [6:0]      coins_left_q, coins_left_d;
  logic [6:0]      coins_q, coins_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [2:0]      hrow_q, hrow_d;
  logic [3:0]      hcol_q, hcol_d;
  logic [1:0]      hit_ack_q, hit_ack_d;
  logic            coin_pulse_q, coin_pulse_d;
  logic            level_done_q, level_done_d;
  logic            load_ready_q, load_ready_d;
  logic            map_ready_q, map_ready_d;
  step_t           step_type_q, step_type_d;
  logic [10:0]     tlx_q, tlx_d;
  logic [10:0]     tly_q, tly_d;

  logic [1:0]      arb_req, arb_gnt;
  logic            arb_en;
  logic [IDXW-1:0] hit_idx;
  logic            hit_in_rng;
  logic [10:0]     lk_col, lk_row;

`ifdef STEP_MAP_BRAKE_RESTORE_EN
  localparam int RCW = $clog2(RESTORE_FRAMES + 1);
  logic [NTILES-1:0] pend_q, pend_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic              rrun_q, rrun_d;
`else
  logic unused_sof;
  assign unused_sof = startOfFrame;
`endif

  // A requester is masked while its ack is out, so a held request is never served twice.
  assign arb_req = (state_q == ST_RUN) ? (hit_valid & ~hit_ack_q) : 2'b00;
  assign arb_en  = (state_q == ST_RUN) && !start_level;

  rr_arb2 u_arb (
    .clk    (clk),
    .resetN (resetN),
    .req    (arb_req),
    .en     (arb_en),
    .gnt    (arb_gnt)
  );

  assign hit_in_rng = (int'(hrow_q) < NUM_OF_ROWS) && (int'(hcol_q) < NUM_OF_COLS);
  assign hit_idx    = IDXW'(int'(hrow_q) * NUM_OF_COLS + int'(hcol_q));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    map_d        = map_q;
    coins_left_d = coins_left_q;
    coins_d      = coins_q;
    gnt_d        = gnt_q;
    hrow_d       = hrow_q;
    hcol_d       = hcol_q;
    hit_ack_d    = 2'b00;
    coin_pulse_d = 1'b0;
    level_done_d = 1'b0;
`ifdef STEP_MAP_BRAKE_RESTORE_EN
    pend_d = pend_q;
    rcnt_d = rcnt_q;
    rrun_d = rrun_q;
    if (startOfFrame && rrun_q && (int'(rcnt_q) < RESTORE_FRAMES)) begin
      rcnt_d = rcnt_q + RCW'(1);
    end
`endif
    if (start_level) begin
      // Restart from any state; an in-flight EXEC is dropped without write or ack.
      state_d = ST_CLEAR;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          map_d[idx_q] = FREE;
          coins_left_d = 7'd0;
`ifdef STEP_MAP_BRAKE_RESTORE_EN
          pend_d = '0;
          rcnt_d = '0;
          rrun_d = 1'b0;
`endif
          if (idx_q == IDXW'(LAST_IDX)) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            map_d[idx_q] = step_t'(load_type);
            if (load_type == COIN) begin
              coins_left_d = coins_left_q + 7'd1;
            end
            if (idx_q == IDXW'(LAST_IDX)) begin
              idx_d   = '0;
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + IDXW'(1);
            end
          end
        end
        ST_RUN: begin
          if (arb_gnt != 2'b00) begin
            gnt_d   = arb_gnt;
            hrow_d  = arb_gnt[1] ? hit_row[1] : hit_row[0];
            hcol_d  = arb_gnt[1] ? hit_col[1] : hit_col[0];
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          hit_ack_d = gnt_q;
          state_d   = ST_RUN;
          if (hit_in_rng) begin
            if (map_q[hit_idx] == COIN) begin
              map_d[hit_idx] = FREE;
              coin_pulse_d   = 1'b1;
              coins_d        = sat_inc7(coins_q);
              if (coins_left_q != 7'd0) begin
                coins_left_d = coins_left_q - 7'd1;
              end
              level_done_d = (coins_left_q == 7'd1);
            end else if (map_q[hit_idx] == BRAKE) begin
              map_d[hit_idx] = FREE;
`ifdef STEP_MAP_BRAKE_RESTORE_EN
              pend_d[hit_idx] = 1'b1;
              rcnt_d          = '0;
              rrun_d          = 1'b1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
`ifdef STEP_MAP_BRAKE_RESTORE_EN
    // Bulk restore only from RUN so it never races an EXEC read-modify-write.
    if (!start_level && (state_q == ST_RUN) && rrun_q && (int'(rcnt_q) == RESTORE_FRAMES)) begin
      for (int i = 0; i < NTILES; i++) begin
        if (pend_q[i]) begin
          map_d[i] = BRAKE;
        end
      end
      pend_d = '0;
      rcnt_d = '0;
      rrun_d = 1'b0;
    end
`endif
    load_ready_d = (state_d == ST_LOAD);
    map_ready_d  = (state_d == ST_RUN);
  end

  assign lk_col = pixelX >> TW_SH;
  assign lk_row = pixelY >> TH_SH;

  always_comb begin
    step_type_d = FREE;
    tlx_d       = 11'd0;
    tly_d       = 11'd0;
    if ((int'(lk_col) < NUM_OF_COLS) && (int'(lk_row) < NUM_OF_ROWS)) begin
      step_type_d = map_q[IDXW'(int'(lk_row) * NUM_OF_COLS + int'(lk_col))];
      tlx_d       = lk_col << TW_SH;
      tly_d       = lk_row << TH_SH;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      for (int i = 0; i < NTILES; i++) begin
        map_q[i] <= FREE;
      end
      coins_left_q <= 7'd0;
      coins_q      <= 7'd0;
      gnt_q        <= 2'b00;
      hrow_q       <= 3'd0;
      hcol_q       <= 4'd0;
      hit_ack_q    <= 2'b00;
      coin_pulse_q <= 1'b0;
      level_done_q <= 1'b0;
      load_ready_q <= 1'b0;
      map_ready_q  <= 1'b0;
      step_type_q  <= FREE;
      tlx_q        <= 11'd0;
      tly_q        <= 11'd0;
`ifdef STEP_MAP_BRAKE_RESTORE_EN
      pend_q       <= '0;
      rcnt_q       <= '0;
      rrun_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      map_q        <= map_d;
      coins_left_q <= coins_left_d;
      coins_q      <= coins_d;
      gnt_q        <= gnt_d;
      hrow_q       <= hrow_d;
      hcol_q       <= hcol_d;
      hit_ack_q    <= hit_ack_d;
      coin_pulse_q <= coin_pulse_d;
      level_done_q <= level_done_d;
      load_ready_q <= load_ready_d;
      map_ready_q  <= map_ready_d;
      step_type_q  <= step_type_d;
      tlx_q        <= tlx_d;
      tly_q        <= tly_d;
`ifdef STEP_MAP_BRAKE_RESTORE_EN
      pend_q       <= pend_d;
      rcnt_q       <= rcnt_d;
      rrun_q       <= rrun_d;
`endif
    end
  end

  assign load_ready      = load_ready_q;
  assign map_ready       = map_ready_q;
  assign hit_ack         = hit_ack_q;
  assign coin_pulse      = coin_pulse_q;
  assign level_done      = level_done_q;
  assign coins_collected = coins_q;
  assign step_type       = step_type_q;
  assign tileTopLeftX    = tlx_q;
  assign tileTopLeftY    = tly_q;

endmodule

// File: tb/tb_step_map_ctrl.sv
// Randomized bench for step_map_ctrl against a tile-array/coin-count reference model.
module tb_step_map_ctrl;

  localparam logic [2:0] T_FREE  = 3'd0;
  localparam logic [2:0] T_REGU  = 3'd1;
  localparam logic [2:0] T_COIN  = 3'd3;
  localparam logic [2:0] T_WALL  = 3'd4;
  localparam logic [2:0] T_BRAKE = 3'd6;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic [10:0]     pixelX = '0, pixelY = '0;
  logic            startOfFrame = 1'b0, start_level = 1'b0;
  logic            load_valid = 1'b0;
  logic [2:0]      load_type = '0;
  logic            load_ready;
  logic [1:0]      hit_valid = '0;
  logic [1:0][2:0] hit_row = '0;
  logic [1:0][3:0] hit_col = '0;
  logic [1:0]      hit_ack;
  logic [10:0]     tileTopLeftX, tileTopLeftY;
  logic [2:0]      step_type;
  logic [6:0]      coins_collected;
  logic            coin_pulse, level_done, map_ready;

  always #5 clk = ~clk;

  step_map_ctrl dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .start_level(start_level),
    .load_valid(load_valid), .load_type(load_type), .load_ready(load_ready),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col), .hit_ack(hit_ack),
    .tileTopLeftX(tileTopLeftX), .tileTopLeftY(tileTopLeftY), .step_type(step_type),
    .coins_collected(coins_collected), .coin_pulse(coin_pulse),
    .level_done(level_done), .map_ready(map_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] m_map [70];
  logic [2:0] lvl   [70];
  int m_coins, m_left, m_last;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [2:0] rand_noncoin();
    int v;
    v = $urandom_range(0, 5);
    return (v >= 3) ? 3'(v + 1) : 3'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 70; i++) m_map[i] = T_FREE;
    m_coins = 0;
    m_left  = 0;
    m_last  = 1;
  endtask

  // Lookup of pixel (x,y): expected from col=x/64, row=y/64 against the model map.
  task automatic check_pix(input int x, input int y, input string nm);
    logic [2:0]  et;
    logic [10:0] ex, ey;
    int c, r;
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(posedge clk); #1;
    c = x / 64;
    r = y / 64;
    et = T_FREE; ex = '0; ey = '0;
    if (c < 10 && r < 7) begin
      et = m_map[r * 10 + c];
      ex = 11'(c * 64);
      ey = 11'(r * 64);
    end
    checks++;
    if (step_type !== et || tileTopLeftX !== ex || tileTopLeftY !== ey) begin
      errors++;
      $display("FAIL %s pix(%0d,%0d): got type=%0d tl=(%0d,%0d) want type=%0d tl=(%0d,%0d)",
               nm, x, y, step_type, tileTopLeftX, tileTopLeftY, et, ex, ey);
    end
  endtask

  task automatic load_level(input string nm);
    int cyc, i, gap;
    logic ok_stream, bad_ack;
    start_level = 1'b1;
    @(posedge clk); #1;
    start_level = 1'b0;
    hit_valid = 2'b11;
    cyc = 0; bad_ack = 1'b0;
    while (load_ready !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (hit_ack !== 2'b00) bad_ack = 1'b1;
    end
    hit_valid = 2'b00;
    checks++;
    if (cyc != 70 || bad_ack) begin
      errors++;
      $display("FAIL %s clear: got %0d cycles ack_seen=%0d, want 70 cycles no ack", nm, cyc, bad_ack);
    end
    i = 0; gap = 0; ok_stream = 1'b1; cyc = 0;
    while (i < 70 && cyc < 400) begin
      if (load_ready !== 1'b1 || map_ready !== 1'b0) ok_stream = 1'b0;
      if (i == 35 && gap < 5) begin
        load_valid = 1'b0;
        gap++;
      end else begin
        load_valid = 1'b1;
        load_type  = lvl[i];
      end
      @(posedge clk); #1;
      cyc++;
      if (load_valid) i++;
    end
    load_valid = 1'b0;
    m_left = 0;
    for (int k = 0; k < 70; k++) begin
      m_map[k] = lvl[k];
      if (lvl[k] == T_COIN) m_left++;
    end
    checks++;
    if (!ok_stream || i != 70 || map_ready !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s load: tiles=%0d stream_ok=%0d map_ready=%0d load_ready=%0d, want 70 1 1 0",
               nm, i, ok_stream, map_ready, load_ready);
    end
  endtask

  // Requesters hold until acked; model picks the winner (last winner loses ties) and applies tile rules.
  task automatic run_hits(input logic [1:0] req, input int r0, input int c0, input int r1, input int c1, input string nm);
    logic [1:0] pend;
    int cyc, since, w, r, c;
    logic ec, ed;
    pend = req;
    hit_row[0] = 3'(r0); hit_col[0] = 4'(c0);
    hit_row[1] = 3'(r1); hit_col[1] = 4'(c1);
    hit_valid = pend;
    cyc = 0; since = 0;
    while (pend != 2'b00 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++; since++;
      if (hit_ack != 2'b00) begin
        w = (pend == 2'b11) ? ((m_last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
        checks++;
        if (hit_ack !== (2'b01 << w) || since != 2) begin
          errors++;
          $display("FAIL %s ack: got %b after %0d cycles, want %b after 2", nm, hit_ack, since, 2'b01 << w);
        end
        m_last = w;
        r = w ? r1 : r0;
        c = w ? c1 : c0;
        ec = 1'b0; ed = 1'b0;
        if (r < 7 && c < 10) begin
          if (m_map[r * 10 + c] == T_COIN) begin
            m_map[r * 10 + c] = T_FREE;
            ec = 1'b1;
            if (m_coins < 127) m_coins++;
            if (m_left > 0) m_left--;
            ed = (m_left == 0);
          end else if (m_map[r * 10 + c] == T_BRAKE) begin
            m_map[r * 10 + c] = T_FREE;
          end
        end
        checks++;
        if (coin_pulse !== ec || level_done !== ed || coins_collected !== 7'(m_coins)) begin
          errors++;
          $display("FAIL %s effect (%0d,%0d): got pulse=%0d done=%0d coins=%0d want %0d %0d %0d",
                   nm, r, c, coin_pulse, level_done, coins_collected, ec, ed, m_coins);
        end
        pend[w] = 1'b0;
        hit_valid = pend;
        since = 0;
      end else if (coin_pulse !== 1'b0 || level_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s spurious pulse: coin_pulse=%0d level_done=%0d without ack", nm, coin_pulse, level_done);
      end
    end
    hit_valid = 2'b00;
    if (pend != 2'b00) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: pending %b, want all acked", nm, pend);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic bad;
    resetN = 1'b0;
    model_reset();
    #2;
    checks++;
    if (step_type !== 3'd0 || map_ready !== 1'b0 || coins_collected !== 7'd0 || hit_ack !== 2'b00 ||
        load_ready !== 1'b0 || coin_pulse !== 1'b0 || level_done !== 1'b0 || tileTopLeftX !== 11'd0) begin
      errors++;
      $display("FAIL reset outputs: type=%0d map_ready=%0d coins=%0d ack=%b load_ready=%0d, want all 0",
               step_type, map_ready, coins_collected, hit_ack, load_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    resetN = 1'b1;
    hit_valid = 2'b11;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (hit_ack !== 2'b00) bad = 1'b1;
    end
    hit_valid = 2'b00;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle hit: got ack in IDLE, want none");
    end
    check_pix(100, 100, "post_reset");
  endtask

  task automatic test_level_load();
    for (int i = 0; i < 70; i++) lvl[i] = rand_noncoin();
    lvl[12] = T_COIN;
    lvl[13] = T_BRAKE;
    lvl[69] = T_WALL;
    load_level("level_load");
    check_pix(130, 70, "coin_tile");
    check_pix(200, 80, "brake_tile");
  endtask

  task automatic test_arbitration();
    run_hits(2'b11, 1, 3, 6, 9, "arb");
    check_pix(3 * 64 + 7, 64 + 9, "arb_brake");
    check_pix(9 * 64 + 63, 6 * 64 + 63, "arb_wall");
  endtask

  task automatic test_coin_collect();
    run_hits(2'b01, 1, 2, 0, 0, "coin");
    check_pix(130, 70, "coin_gone");
  endtask

  task automatic test_edges();
    run_hits(2'b01, 7, 12, 0, 0, "oor_hit");
    run_hits(2'b10, 0, 11, 0, 0, "oor_col");
    check_pix(650, 10, "pix_x_oor");
    check_pix(639, 447, "pix_last");
    check_pix(5, 448, "pix_y_oor");
    check_pix(2047, 2047, "pix_max");
  endtask

  task automatic test_random();
    int r0, c0, r1, c1;
    for (int i = 0; i < 70; i++) lvl[i] = 3'($urandom_range(0, 6));
    load_level("rand_load");
    for (int n = 0; n < 30; n++) begin
      r0 = $urandom_range(0, 7);
      c0 = $urandom_range(0, 11);
      r1 = $urandom_range(0, 7);
      c1 = $urandom_range(0, 11);
      if ($urandom_range(0, 3) == 0) begin
        r1 = r0;
        c1 = c0;
      end
      run_hits(2'($urandom_range(1, 3)), r0, c0, r1, c1, "rand_hit");
    end
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 10; c++)
        check_pix(c * 64 + $urandom_range(0, 63), r * 64 + $urandom_range(0, 63), "rand_map");
  endtask

  task automatic test_abort();
    int cyc;
    logic bad;
    for (int i = 0; i < 70; i++) lvl[i] = T_REGU;
    lvl[0] = T_COIN;
    load_level("abort_load");
    hit_row[0] = 3'd0; hit_col[0] = 4'd0;
    hit_valid = 2'b01;
    @(posedge clk); #1;
    m_last = 0;
    start_level = 1'b1;
    hit_valid = 2'b00;
    @(posedge clk); #1;
    start_level = 1'b0;
    checks++;
    if (hit_ack !== 2'b00 || coin_pulse !== 1'b0 || coins_collected !== 7'(m_coins) || map_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort: ack=%b pulse=%0d coins=%0d map_ready=%0d, want 00 0 %0d 0",
               hit_ack, coin_pulse, coins_collected, map_ready, m_coins);
    end
    cyc = 0; bad = 1'b0;
    while (load_ready !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (hit_ack !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (cyc != 70 || bad) begin
      errors++;
      $display("FAIL abort clear: got %0d cycles ack_seen=%0d, want 70 no ack", cyc, bad);
    end
    for (int i = 0; i < 70; i++) m_map[i] = T_FREE;
    m_left = 0;
    check_pix(3, 3, "abort_cleared");
  endtask

  task automatic test_saturation();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 70; i++) lvl[i] = T_COIN;
      load_level("sat_load");
      for (int i = 0; i < 70; i++) run_hits(2'b01, i / 10, i % 10, 0, 0, "sat_hit");
    end
    checks++;
    if (coins_collected !== 7'd127) begin
      errors++;
      $display("FAIL saturation: coins=%0d want 127", coins_collected);
    end
  endtask

  task automatic test_restore();
    for (int i = 0; i < 70; i++) lvl[i] = rand_noncoin();
    lvl[13] = T_BRAKE;
    load_level("restore_load");
    run_hits(2'b01, 1, 3, 0, 0, "restore_break");
    check_pix(200, 70, "brake_broken");
    for (int f = 0; f < 119; f++) begin
      startOfFrame = 1'b1;
      @(posedge clk); #1;
      startOfFrame = 1'b0;
      @(posedge clk); #1;
    end
    check_pix(200, 70, "brake_119");
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef STEP_MAP_BRAKE_RESTORE_EN
    m_map[13] = T_BRAKE;
`endif
    check_pix(200, 70, "brake_120");
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    checks++;
    if (step_type !== 3'd0 || map_ready !== 1'b0 || coins_collected !== 7'd0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: type=%0d map_ready=%0d coins=%0d load_ready=%0d, want 0",
               step_type, map_ready, coins_collected, load_ready);
    end
    model_reset();
    @(posedge clk); #1;
    resetN = 1'b1;
    check_pix(20, 20, "mid_reset_map");
  endtask

  initial begin
    test_reset();
    test_level_load();
    test_arbitration();
    test_coin_collect();
    test_edges();
    test_random();
    test_abort();
    test_saturation();
    test_restore();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
